// File: rtl/lc3_mem_pkg.sv
// Shared memory-side types and constants for the LC-3 line fill path.
package lc3_mem_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 16;
  localparam int OFFSET_W   = 4;
  localparam int BYTE_OFF_W = 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [LINE_WORDS-1:0] line_t;

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_t;

endpackage

// File: rtl/line_fill_buffer_fill_sequencer.sv
// Control half of the line fill buffer: request acceptance, critical-word-first
// burst sequencing, memory address generation and the critical-word pulse.
module fill_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic                  inval_i,
  input  logic                  mem_resp_i,
  output logic                  req_ready_o,
  output logic                  mem_read_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  line_valid_o,
  output logic [ADDR_W-6:0]     line_base_o,
  output logic                  crit_valid_o,
  output logic [OFFSET_W-1:0]   crit_sel_o,
  output logic                  slot_we_o,
  output logic [OFFSET_W-1:0]   slot_idx_o,
  output logic                  crit_capture_o
);

  localparam int LB_W = ADDR_W - 5;

  fill_state_t           state_q, state_d;
  logic [OFFSET_W-1:0]   beat_q, beat_d;
  logic [OFFSET_W-1:0]   critSel_q, critSel_d;
  logic [LB_W-1:0]       lineBase_q, lineBase_d;
  logic [ADDR_W-1:0]     memAddr_q, memAddr_d;
  logic                  critValid_q, critValid_d;
  logic                  lineValid_q, lineValid_d;
  logic [OFFSET_W-1:0]   idx;
  logic                  respTake;

  // 4-bit add gives the wrap-around order for free.
  assign idx = critSel_q + beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      critSel_q   <= '0;
      lineBase_q  <= '0;
      memAddr_q   <= '0;
      critValid_q <= 1'b0;
      lineValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      critSel_q   <= critSel_d;
      lineBase_q  <= lineBase_d;
      memAddr_q   <= memAddr_d;
      critValid_q <= critValid_d;
      lineValid_q <= lineValid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    critSel_d   = critSel_q;
    lineBase_d  = lineBase_q;
    memAddr_d   = memAddr_q;
    critValid_d = 1'b0;
    lineValid_d = lineValid_q;
    case (state_q)
      IDLE: begin
        // Invalidate wins over a simultaneous request, which stays pending.
        if (inval_i) begin
          lineValid_d = 1'b0;
        end else if (req_valid_i) begin
          state_d     = FILL;
          beat_d      = '0;
          critSel_d   = req_addr_i[4:1];
          lineBase_d  = req_addr_i[ADDR_W-1:5];
          memAddr_d   = {req_addr_i[ADDR_W-1:1], 1'b0};
          lineValid_d = 1'b0;
        end
      end
      FILL: begin
        if (inval_i) begin
          state_d = IDLE;
        end else if (mem_resp_i) begin
          beat_d      = beat_q + 4'd1;
          memAddr_d   = {lineBase_q, idx + 4'd1, 1'b0};
          critValid_d = (beat_q == 4'd0);
          if (beat_q == 4'hF) begin
            state_d     = IDLE;
            lineValid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    respTake       = (state_q == FILL) && mem_resp_i && !inval_i;
    req_ready_o    = (state_q == IDLE);
    mem_read_o     = (state_q == FILL);
    slot_we_o      = respTake;
    slot_idx_o     = idx;
    crit_capture_o = respTake && (beat_q == 4'd0);
  end

  assign mem_addr_o   = memAddr_q;
  assign line_valid_o = lineValid_q;
  assign line_base_o  = lineBase_q;
  assign crit_valid_o = critValid_q;
  assign crit_sel_o   = critSel_q;

endmodule

// File: rtl/line_fill_buffer.sv
// Line fill buffer: 16-slot line storage fed by a critical-word-first burst,
// packed flat for the downstream 16:1 word-select mux.
module line_fill_buffer
  import lc3_mem_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic                        inval_i,
  output logic                        mem_read_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  input  logic [WIDTH-1:0]            mem_rdata_i,
  input  logic                        mem_resp_i,
  output logic [LINE_WORDS*WIDTH-1:0] line_data_o,
  output logic                        line_valid_o,
  output logic [ADDR_W-6:0]           line_base_o,
  output logic                        crit_valid_o,
  output logic [WIDTH-1:0]            crit_word_o,
  output logic [OFFSET_W-1:0]         crit_sel_o
);

  logic [WIDTH-1:0]    slots_q [LINE_WORDS];
  logic [WIDTH-1:0]    critWord_q;
  logic                slotWe;
  logic [OFFSET_W-1:0] slotIdx;
  logic                critCapture;

  fill_sequencer #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .inval_i        (inval_i),
    .mem_resp_i     (mem_resp_i),
    .req_ready_o    (req_ready_o),
    .mem_read_o     (mem_read_o),
    .mem_addr_o     (mem_addr_o),
    .line_valid_o   (line_valid_o),
    .line_base_o    (line_base_o),
    .crit_valid_o   (crit_valid_o),
    .crit_sel_o     (crit_sel_o),
    .slot_we_o      (slotWe),
    .slot_idx_o     (slotIdx),
    .crit_capture_o (critCapture)
  );

  // Slots are only written by accepted responses, so a valid line stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        slots_q[k] <= '0;
      end
    end else if (slotWe) begin
      slots_q[slotIdx] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      critWord_q <= '0;
    end else if (critCapture) begin
      critWord_q <= mem_rdata_i;
    end
  end

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_pack
    assign line_data_o[k*WIDTH +: WIDTH] = slots_q[k];
  end

  assign crit_word_o = critWord_q;

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
Collects one 16-word cache line from physical memory as a critical-word-first, wrap-around burst of single-word reads. Presents the assembled line as 16 parallel words to the downstream 16:1 word-select mux (slot k drives mux input k, sel = word offset). Forwards the critical word one cycle early so the pipeline can restart before the fill completes.

Parameters:
WIDTH, 16, bits per word; matches the word-select mux width.
ADDR_W, 16, byte-address width. Line = 16 words = 32 bytes, so offset = addr[4:1], line base = addr[ADDR_W-1:5].

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fill request
req_ready  out  1  block can accept a request (IDLE)
req_addr  in  ADDR_W  byte address of the missing word
inval  in  1  clear line_valid; abort any fill in progress
mem_read  out  1  read strobe to physical memory
mem_addr  out  ADDR_W  word-aligned read address
mem_rdata  in  WIDTH  read data
mem_resp  in  1  one-cycle completion of the current read
line_data  out  16*WIDTH  slot k at bits [k*WIDTH +: WIDTH]; feeds the 16:1 mux
line_valid  out  1  all 16 slots hold the line named by line_base
line_base  out  ADDR_W-5  line address of line_data
crit_valid  out  1  one-cycle pulse: critical word available
crit_word  out  WIDTH  critical word; valid while crit_valid is high
crit_sel  out  4  word offset of the critical word; also the mux sel for it

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, mem_read=0, mem_addr=0, line_valid=0, line_base=0, crit_valid=0, crit_word=0, crit_sel=0, beat=0, all line_data slots=0.
- States: IDLE and FILL.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1 and inval=0. Register line_base=req_addr[ADDR_W-1:5], crit_sel=req_addr[4:1], beat=0.
  - Clear line_valid and enter FILL on the next edge.
  - req_valid together with inval in the same cycle: inval wins; the request is not accepted and stays pending.
- FILL:
  - req_ready=0 and mem_read=1 continuously.
  - idx = (crit_sel + beat) mod 16, using 4-bit wrap. mem_addr = {line_base, idx, 1'b0}, registered, so it changes only on the edge after mem_resp.
  - On mem_resp: slot[idx] <= mem_rdata, beat <= beat+1.
  - On the beat=0 response: register crit_word=mem_rdata and pulse crit_valid high for exactly the next cycle.
  - On the beat=15 response: line_valid <= 1 and state <= IDLE. mem_read is low the following cycle.
  - Fill latency is 16 responses. The block never issues more than 16 reads per request.
- inval in FILL:
  - Takes effect on the next edge: state <= IDLE, mem_read <= 0, line_valid stays 0.
  - A mem_resp in the same cycle is discarded. No slot write, and no crit_valid pulse even if beat=0.
- inval in IDLE: line_valid <= 0. line_data and line_base are retained but meaningless.
- Slots from an aborted fill keep stale or partial data. Consumers rely only on line_valid.
- Wrap-around: crit_sel=0xF fetches offsets F,0,1,…,E. crit_sel=0 fetches 0..F linearly.
- line_data only changes during FILL. When line_valid=1 it is stable until the next accepted request or until reset.
- Reset asserted mid-FILL: immediate return to reset values, and mem_read drops asynchronously.

Decomposition:
- Shared package lc3_mem_pkg:
  - LINE_WORDS=16, OFFSET_W=4, BYTE_OFF_W=1.
  - typedef word_t (logic [WIDTH-1:0]).
  - typedef line_t (word_t [15:0]).
  - typedef enum fill_state_t {IDLE, FILL}.
- One sub-module, fill_sequencer: the state register, beat counter, idx/mem_addr generation and the crit_valid pulse. The top level holds the 16-slot storage and the output packing.

Test Plan:
- Linear fill:
  - Stimulus: req_addr=0x1200, memory returns data = 0xA000|offset with a 2-cycle response delay.
  - Required: mem_addr steps 0x1200,0x1202,…,0x121E. crit_word=0xA000 with crit_valid pulsing once. line_valid=1 after the 16th resp. Slot k = 0xA000+k, line_base=0x090.
- Critical-word wrap:
  - Stimulus: req_addr=0x345E (offset F).
  - Required: addresses 0x345E,0x3440,0x3442,…,0x345C. crit_sel=0xF. Slot 15 is filled first. line_valid only after 16 responses.
- Abort mid-fill:
  - Stimulus: inval in the same cycle as the 5th mem_resp.
  - Required: that word is not written. mem_read=0 next cycle, state IDLE, line_valid=0, req_ready=1.
- Request/inval collision:
  - Stimulus: in IDLE with line_valid=1, assert req_valid and inval together for one cycle, then req_valid alone.
  - Required: first cycle → line_valid=0 and no fill. Second cycle → accepted, FILL begins.
- Async reset mid-fill:
  - Stimulus: drop rst_n between clock edges at beat 7.
  - Required: mem_read, line_valid and crit_valid go to 0 without waiting for clk. After release, req_ready=1.
- Back-to-back fills:
  - Stimulus: second request immediately after line_valid rises.
  - Required: accepted the first cycle req_ready=1. line_valid falls on acceptance, and crit_valid pulses again for the new line.
